// File: rtl/sid_spi_writer.sv
// SPI master that queues SID register writes and shifts each one out as the
// two-byte frame {1,addr[4:0],data[7:6]} {00,data[5:0]}, mode 0, MSB first.
module sid_spi_writer #(
  parameter int CLK_DIV = 6,   // clk cycles per SCK half-period, >= 3
  parameter int FIFO_AW = 2,   // log2 of request FIFO depth
  parameter int CS_GAP  = 12   // min clk cycles CS_n high between frames, >= 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [4:0] i_addr,
  input  logic [7:0] i_data,
  output logic       o_sck,
  output logic       o_mosi,
  output logic       o_cs_n,
  output logic       o_busy,
  output logic       o_done
);

  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]    HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]    GAP_LAST  = CW'(CS_GAP - 1);
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } req_t;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  req_t                mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    count_q, count_d;

  logic   fifo_full;
  logic   fifo_empty;
  logic   push;
  logic   pop;
  req_t   head;

  // ---------------------------------------------------------------------------
  // Shifter / FSM
  // ---------------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     bit_q, bit_d;
  logic [15:0]    shreg_q, shreg_d;
  logic           sck_q, sck_d;
  logic           mosi_q, mosi_d;
  logic           cs_n_q, cs_n_d;
  logic           done_q, done_d;
  logic [15:0]    frame_w;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);

  // A push while full is dropped even if the FSM pops in the same cycle.
  assign push = i_valid && !fifo_full;
  assign pop  = (state_q == ST_IDLE) && !fifo_empty;
  assign head = mem_q[rd_ptr_q];

  assign frame_w = {1'b1, head.addr, head.data[7:6], 2'b00, head.data[5:0]};

  // NOTE: payload storage has no reset; validity is tracked by the pointers and
  // count, so resetting the array would only cost flops and a reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: i_addr, data: i_data};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          shreg_d = frame_w;
          mosi_d  = frame_w[15];
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (sck_q) begin
            // Falling edge: advance MOSI so it is settled well before the next rise.
            sck_d   = 1'b0;
            shreg_d = {shreg_q[14:0], 1'b0};
            mosi_d  = shreg_q[14];
          end else if (bit_q == 4'd15) begin
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_GAP;
          end else begin
            sck_d = 1'b1;
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      done_q   <= done_d;
    end
  end

  assign o_sck   = sck_q;
  assign o_mosi  = mosi_q;
  assign o_cs_n  = cs_n_q;
  assign o_done  = done_q;
  assign o_ready = !fifo_full;
  assign o_busy  = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sid_spi_writer.sv
// Self-checking bench: random SID writes are pushed into two writer instances and
// the SPI pins are decoded back into frames and compared with a behavioural model.
module tb_sid_spi_writer;

  localparam int D0 = 6, G0 = 12;
  localparam int D1 = 3, G1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic [4:0] addr0 = '0, addr1 = '0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       ready0, ready1, sck0, sck1, mosi0, mosi1;
  logic       cs0, cs1, busy0, busy1, done0, done1;

  sid_spi_writer #(.CLK_DIV(D0), .FIFO_AW(2), .CS_GAP(G0)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(valid0), .o_ready(ready0),
    .i_addr(addr0), .i_data(data0), .o_sck(sck0), .o_mosi(mosi0),
    .o_cs_n(cs0), .o_busy(busy0), .o_done(done0)
  );

  sid_spi_writer #(.CLK_DIV(D1), .FIFO_AW(2), .CS_GAP(G1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .i_valid(valid1), .o_ready(ready1),
    .i_addr(addr1), .i_data(data1), .o_sck(sck1), .o_mosi(mosi1),
    .o_cs_n(cs1), .o_busy(busy1), .o_done(done1)
  );

  typedef struct { int inst; int addr; int data; } req_t;
  typedef struct {
    int          inst;
    logic [15:0] frame;
    int          nbits;
    int          cs_low;
    int          per_min;
    int          per_max;
    int          mosi_glitch;
    int          spacing;
    int          gap_high;
    logic        done;
  } rec_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  req_t exp_q[$];
  rec_t obs_q[$];
  int   done_exp[2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference frame built from the byte rules: 1AAAAADD then 00DDDDDD.
  function automatic logic [15:0] frame_of(input int a, input int d);
    int b0 = 128 + a * 4 + d / 64;
    int b1 = d % 64;
    return 16'(b0 * 256 + b1);
  endfunction

  // ---------------------------------------------------------------------------
  // Pin monitor: rebuilds frames and timing from SCK/MOSI/CS_n of each instance
  // ---------------------------------------------------------------------------
  logic [1:0] sck_v, cs_v, mosi_v, done_v;
  assign sck_v  = {sck1, sck0};
  assign cs_v   = {cs1, cs0};
  assign mosi_v = {mosi1, mosi0};
  assign done_v = {done1, done0};

  rec_t cur[2];
  logic p_cs[2]        = '{1'b1, 1'b1};
  logic p_sck[2]       = '{1'b0, 1'b0};
  logic rise_mosi[2]   = '{1'b0, 1'b0};
  bit   have_fall[2]   = '{0, 0};
  bit   have_rise[2]   = '{0, 0};
  int   last_fall[2]   = '{0, 0};
  int   last_csrise[2] = '{0, 0};
  int   last_rise_t[2] = '{-1, -1};
  int   last_cs_tog[2] = '{-100, -100};
  int   last_sck_tog[2] = '{-100, -100};
  int   viol[2]        = '{0, 0};
  int   done_total[2]  = '{0, 0};
  int   nbits_now[2]   = '{0, 0};

  always @(negedge clk) begin
    logic s, c, m, d;
    int   per;
    for (int i = 0; i < 2; i++) begin
      s = sck_v[i]; c = cs_v[i]; m = mosi_v[i]; d = done_v[i];
      if (!c && p_cs[i]) begin
        cur[i].inst        = i;
        cur[i].frame       = '0;
        cur[i].nbits       = 0;
        cur[i].cs_low      = 0;
        cur[i].per_min     = 1000000;
        cur[i].per_max     = 0;
        cur[i].mosi_glitch = 0;
        cur[i].done        = 1'b0;
        cur[i].spacing     = have_fall[i] ? cyc - last_fall[i] : 0;
        cur[i].gap_high    = have_rise[i] ? cyc - last_csrise[i] : 0;
        last_fall[i]   = cyc;
        have_fall[i]   = 1'b1;
        last_rise_t[i] = -1;
      end
      if (!c) begin
        cur[i].cs_low++;
        if (s && !p_sck[i]) begin
          cur[i].frame = {cur[i].frame[14:0], m};
          cur[i].nbits++;
          if (last_rise_t[i] >= 0) begin
            per = cyc - last_rise_t[i];
            if (per < cur[i].per_min) cur[i].per_min = per;
            if (per > cur[i].per_max) cur[i].per_max = per;
          end
          last_rise_t[i] = cyc;
          rise_mosi[i]   = m;
        end else if (s && p_sck[i] && (m !== rise_mosi[i])) begin
          cur[i].mosi_glitch++;
        end
      end
      if (c && !p_cs[i]) begin
        cur[i].done = d;
        obs_q.push_back(cur[i]);
        last_csrise[i] = cyc;
        have_rise[i]   = 1'b1;
      end
      if (d) done_total[i]++;
      // SCK and CS_n must never toggle within one clk cycle of each other.
      if (rst_n) begin
        if (c != p_cs[i]) begin
          if (cyc - last_sck_tog[i] <= 1) viol[i]++;
          last_cs_tog[i] = cyc;
        end
        if (s != p_sck[i]) begin
          if (cyc - last_cs_tog[i] <= 1) viol[i]++;
          last_sck_tog[i] = cyc;
        end
      end
      nbits_now[i] = cur[i].nbits;
      p_cs[i]  = c;
      p_sck[i] = s;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input int inst, input logic v, input int a, input int d);
    if (inst == 0) begin
      valid0 = v; addr0 = 5'(a); data0 = 8'(d);
    end else begin
      valid1 = v; addr1 = 5'(a); data1 = 8'(d);
    end
  endtask

  function automatic logic rdy(input int inst);
    return (inst == 0) ? ready0 : ready1;
  endfunction

  function automatic logic bsy(input int inst);
    return (inst == 0) ? busy0 : busy1;
  endfunction

  task automatic push(input int inst, input int a, input int d);
    int budget = 3000;
    @(negedge clk);
    drive(inst, 1'b1, a, d);
    while (!rdy(inst) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("push accepted in time", 32'(budget > 0), 32'd1);
    if (budget > 0) begin
      exp_q.push_back('{inst, a, d});
      done_exp[inst]++;
    end
    @(negedge clk);
    drive(inst, 1'b0, 0, 0);
  endtask

  // Holds i_valid high with fresh random requests until `want` are accepted.
  task automatic fill(input int want, output int n_acc, output int acc_when_low,
                      output int t_first, output int t_last);
    int budget = 3000;
    int pa = int'($urandom_range(0, 31));
    int pd = int'($urandom_range(0, 255));
    n_acc = 0; acc_when_low = -1; t_first = 0; t_last = 0;
    while (n_acc < want && budget > 0) begin
      @(negedge clk);
      budget--;
      drive(0, 1'b1, pa, pd);
      if (ready0) begin
        exp_q.push_back('{0, pa, pd});
        done_exp[0]++;
        if (n_acc == 0) t_first = cyc;
        t_last = cyc;
        n_acc++;
        pa = int'($urandom_range(0, 31));
        pd = int'($urandom_range(0, 255));
      end else if (acc_when_low < 0) begin
        acc_when_low = n_acc;
      end
    end
    @(negedge clk);
    drive(0, 1'b0, 0, 0);
  endtask

  task automatic wait_idle(input string tag, input int inst);
    int budget = 3000;
    while (bsy(inst) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, " busy clears"}, 32'(bsy(inst)), 32'd0);
  endtask

  logic [15:0] last_frame;

  // Waits for n frames and compares each against the model; sp is the expected
  // fall-to-fall spacing of back-to-back frames after the first.
  task automatic expect_frames(input string tag, input int n, input int inst,
                               input int d, input int sp);
    int   budget;
    rec_t r;
    req_t q;
    budget = n * (33 * d + 16) + 600;
    while (obs_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, " frame count"}, 32'(obs_q.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (obs_q.size() == 0 || exp_q.size() == 0) break;
      r = obs_q.pop_front();
      q = exp_q.pop_front();
      last_frame = r.frame;
      check({tag, " instance"}, 32'(r.inst), 32'(q.inst));
      check({tag, " frame"}, 32'(r.frame), 32'(frame_of(q.addr, q.data)));
      check({tag, " decoded addr"}, 32'(r.frame[14:10]), 32'(q.addr));
      check({tag, " decoded data"}, 32'({r.frame[9:8], r.frame[5:0]}), 32'(q.data));
      check({tag, " sck rises"}, 32'(r.nbits), 32'd16);
      check({tag, " cs low cycles"}, 32'(r.cs_low), 32'(33 * d));
      check({tag, " sck period min"}, 32'(r.per_min), 32'(2 * d));
      check({tag, " sck period max"}, 32'(r.per_max), 32'(2 * d));
      check({tag, " mosi stable high"}, 32'(r.mosi_glitch), 32'd0);
      check({tag, " done at cs rise"}, 32'(r.done), 32'd1);
      if (k > 0) begin
        check({tag, " frame spacing"}, 32'(r.spacing), 32'(sp));
        check({tag, " cs high gap"}, 32'(r.gap_high), 32'(sp - 33 * d));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int   n_acc, acc_low, t_first, t_last, budget;
    rec_t r;
    req_t q;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset sck", 32'(sck0), 32'd0);
    check("reset mosi", 32'(mosi0), 32'd0);
    check("reset cs_n", 32'(cs0), 32'd1);
    check("reset busy", 32'(busy0), 32'd0);
    check("reset done", 32'(done0), 32'd0);
    check("reset ready", 32'(ready0), 32'd1);
    check("reset cs_n fast", 32'(cs1), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: single write
    push(0, 'h18, 'hAB);
    check("T1 busy in flight", 32'(busy0), 32'd1);
    expect_frames("T1", 1, 0, D0, 0);
    check("T1 bytes E2 2B", 32'(last_frame), 32'hE22B);
    wait_idle("T1", 0);

    // T2: loopback decode, exactly one write strobe
    push(0, 'h04, 'h41);
    expect_frames("T2", 1, 0, D0, 0);
    repeat (300) @(negedge clk);
    check("T2 single strobe", 32'(obs_q.size()), 32'd0);
    wait_idle("T2", 0);

    // Random isolated writes
    for (int k = 0; k < 3; k++) begin
      push(0, int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
      expect_frames("rand", 1, 0, D0, 0);
      wait_idle("rand", 0);
    end

    // T3: six requests with i_valid held high
    fill(6, n_acc, acc_low, t_first, t_last);
    check("T3 accepted", 32'(n_acc), 32'd6);
    check("T3 accepted before full", 32'(acc_low), 32'd5);
    check("T3 sixth accept delay", 32'(t_last - t_first), 32'(33 * D0 + G0 + 3));
    expect_frames("T3", 6, 0, D0, 33 * D0 + G0 + 1);
    wait_idle("T3", 0);

    // T4: push while full coinciding with a pop is dropped
    fill(5, n_acc, acc_low, t_first, t_last);
    check("T4 filled", 32'(n_acc), 32'd5);
    drive(0, 1'b1, 'h15, 'h5A);
    budget = 1000;
    while (!ready0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    drive(0, 1'b0, 0, 0);
    check("T4 slot freed", 32'(ready0), 32'd1);
    push(0, int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
    check("T4 full again after one push", 32'(ready0), 32'd0);
    expect_frames("T4", 6, 0, D0, 33 * D0 + G0 + 1);
    wait_idle("T4", 0);

    // T5: reset at the 7th SCK rising edge
    push(0, int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
    push(0, int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
    budget = 2000;
    while (!(cs0 == 1'b0 && nbits_now[0] == 7) && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    check("T5 reached 7th rise", 32'(nbits_now[0]), 32'd7);
    rst_n = 1'b0;
    #1;
    check("T5 async cs_n", 32'(cs0), 32'd1);
    check("T5 async sck", 32'(sck0), 32'd0);
    check("T5 async mosi", 32'(mosi0), 32'd0);
    check("T5 async busy", 32'(busy0), 32'd0);
    check("T5 async ready", 32'(ready0), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    q = exp_q.pop_front();
    void'(exp_q.pop_front());
    done_exp[0] -= 2;
    budget = 20;
    while (obs_q.size() == 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("T5 partial frame seen", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) begin
      r = obs_q.pop_front();
      check("T5 partial bits", 32'(r.frame[6:0]), 32'(frame_of(q.addr, q.data) >> 9));
      check("T5 partial no done", 32'(r.done), 32'd0);
    end
    repeat (300) @(negedge clk);
    check("T5 fifo discarded", 32'(obs_q.size()), 32'd0);
    check("T5 idle after reset", 32'(busy0), 32'd0);
    push(0, int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
    expect_frames("T5 after reset", 1, 0, D0, 0);
    wait_idle("T5", 0);

    // T6: fast instance, CLK_DIV=3 CS_GAP=1
    push(1, 'h1F, 'hFF);
    push(1, int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
    obs_q.delete();
    expect_frames("T6", 2, 1, D1, 33 * D1 + G1 + 1);
    wait_idle("T6", 1);

    check("glitch rule", 32'(viol[0]), 32'd0);
    check("glitch rule fast", 32'(viol[1]), 32'd0);
    check("done pulses", 32'(done_total[0]), 32'(done_exp[0]));
    check("done pulses fast", 32'(done_total[1]), 32'(done_exp[1]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
